// File: rtl/pipelined_ctrl_unit.sv
// Purpose : RV32 D-stage decoder feeding the E-stage control register. Optional M extension under `RV32M_EN`.
// Latency : ImmSrcD is combinational in D. All other control appears one clock after the instruction loads.
// Backpr. : stall_e or mdu_busy holds E, and flush_e bubbles it. mdu_busy tells the hazard unit to stall F/D/E.
module pipelined_ctrl_unit #(
    parameter int ALUCTRL_W   = 5,
    parameter int IMMSRC_W    = 3,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic                 ALUSrcE,
    output logic [1:0]           ResultSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [IMMSRC_W-1:0]  ImmSrcD,
    output logic                 csr_we_e,
    output logic                 mdu_start,
    output logic                 mdu_busy,
    output logic                 trap_req,
    output logic [3:0]           trap_cause,
    output logic                 mret_req
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [6:0]  F7_MULDIV   = 7'b0000001;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(5'b00000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(5'b00001);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(5'b00100);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(5'b00101);
    localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(5'b01000);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(5'b01001);
    localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(5'b01010);
    localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(5'b10000);
`ifdef RV32M_EN
    localparam logic [ALUCTRL_W-1:0] ALU_MUL   = ALUCTRL_W'(5'b00010);
    localparam logic [ALUCTRL_W-1:0] ALU_DIV   = ALUCTRL_W'(5'b00011);
    localparam logic [ALUCTRL_W-1:0] ALU_REM   = ALUCTRL_W'(5'b00110);
`endif

    localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(3'b000);
    localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(3'b001);
    localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(3'b010);
    localparam logic [IMMSRC_W-1:0] IMM_J = IMMSRC_W'(3'b011);
    localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(3'b100);

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_CSR = 2'b11;

    // Control bundle carried by the E-stage register. An all-zero value is a bubble.
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 alu_src;
        logic                 csr_we;
        logic [1:0]           result_src;
        logic [ALUCTRL_W-1:0] alu_ctrl;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    ctrl_t      dec_ctrl;
    logic       dec_illegal;
    logic       dec_ecall;
    logic       dec_mret;
`ifdef RV32M_EN
    logic       dec_mdu;
    logic       dec_mdu_div;
`endif

    ctrl_t      ctrl_q, ctrl_d;
    logic       trap_req_q, trap_req_d;
    logic [3:0] trap_cause_q, trap_cause_d;
    logic       mret_req_q, mret_req_d;
    logic       load_ok;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];

    // E may accept a new entry only when neither the hazard unit nor an MDU op holds it.
    assign load_ok = ~stall_e & ~mdu_busy;

    // Shared ALU selection for R-type and I-type arithmetic. SLT/SLTU have no code and fall back to ADD.
    function automatic logic [ALUCTRL_W-1:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
        logic [ALUCTRL_W-1:0] op;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Full D-stage decode. Trap and MRET instructions leave dec_ctrl at zero, so they enter E as bubbles.
    always_comb begin
        dec_ctrl    = '0;
        ImmSrcD     = IMM_I;
        dec_illegal = 1'b0;
        dec_ecall   = 1'b0;
        dec_mret    = 1'b0;
`ifdef RV32M_EN
        dec_mdu     = 1'b0;
        dec_mdu_div = 1'b0;
`endif
        case (opcode)
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.result_src = RES_MEM;
                dec_ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = ALU_ADD;
                ImmSrcD            = IMM_S;
            end
            OP_RTYPE: begin
                if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    dec_ctrl.reg_write = 1'b1;
                    dec_mdu            = 1'b1;
                    if (!funct3[2]) begin
                        dec_ctrl.alu_ctrl = ALU_MUL;
                    end else if (!funct3[1]) begin
                        dec_ctrl.alu_ctrl = ALU_DIV;
                        dec_mdu_div       = 1'b1;
                    end else begin
                        dec_ctrl.alu_ctrl = ALU_REM;
                        dec_mdu_div       = 1'b1;
                    end
`else
                    dec_illegal = 1'b1;
`endif
                end else begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_ctrl  = alu_from_funct3(funct3, funct7 == F7_ALT);
                end
            end
            OP_IALU: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = alu_from_funct3(funct3, 1'b0);
            end
            OP_BRANCH: begin
                dec_ctrl.branch   = 1'b1;
                dec_ctrl.alu_ctrl = ALU_SUB;
                ImmSrcD           = IMM_B;
            end
            OP_JAL: begin
                dec_ctrl.jump       = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.result_src = RES_PC4;
                ImmSrcD             = IMM_J;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_ctrl  = ALU_PASSB;
                ImmSrcD            = IMM_U;
            end
            OP_SYSTEM: begin
                if (instr_d == INSTR_ECALL) begin
                    dec_ecall = 1'b1;
                end else if (instr_d == INSTR_MRET) begin
                    dec_mret = 1'b1;
                end else if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    dec_ctrl.reg_write  = 1'b1;
                    dec_ctrl.csr_we     = 1'b1;
                    dec_ctrl.result_src = RES_CSR;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next E-stage entry: flush bubbles, a hold keeps control but drops pulses, otherwise load decode.
    always_comb begin
        ctrl_d       = ctrl_q;
        trap_req_d   = 1'b0;
        trap_cause_d = 4'd0;
        mret_req_d   = 1'b0;
        if (flush_e) begin
            ctrl_d = '0;
        end else if (load_ok) begin
            ctrl_d     = valid_d ? dec_ctrl : '0;
            trap_req_d = valid_d & (dec_illegal | dec_ecall);
            mret_req_d = valid_d & dec_mret;
            if (valid_d && dec_ecall) begin
                trap_cause_d = 4'd11;
            end else if (valid_d && dec_illegal) begin
                trap_cause_d = 4'd2;
            end
        end
    end

    // E-stage pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q       <= '0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= 4'd0;
            mret_req_q   <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            mret_req_q   <= mret_req_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign BranchE     = ctrl_q.branch;
    assign JumpE       = ctrl_q.jump;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign csr_we_e    = ctrl_q.csr_we;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_ctrl;
    assign trap_req    = trap_req_q;
    assign trap_cause  = trap_cause_q;
    assign mret_req    = mret_req_q;

`ifdef RV32M_EN
    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MDU_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1;
    logic             mdu_load;
    logic             start_q;

    assign lat_m1   = dec_mdu_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
    assign mdu_load = valid_d & dec_mdu & ~flush_e & load_ok;
    // The cycle in which the counter reaches zero already releases E, so the next instruction can load.
    assign mdu_busy  = (state_q == S_MDU_WAIT) && (cnt_q != '0);
    assign mdu_start = start_q;

    // MDU sequencer next state: flush aborts, the wait counts down, and a new op reloads the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_e) begin
            state_d = S_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_MDU_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
            if (mdu_load) begin
                cnt_d   = lat_m1;
                state_d = (lat_m1 != '0) ? S_MDU_WAIT : S_RUN;
            end
        end
    end

    // MDU sequencer state, counter and start pulse. Reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= mdu_load;
        end
    end
`else
    // Without the M extension there is no multi-cycle work to sequence.
    logic [31:0] unused_cfg;
    assign unused_cfg = MUL_LATENCY + DIV_LATENCY + CNT_W;
    assign mdu_busy   = 1'b0;
    assign mdu_start  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
module tb_pipelined_ctrl_unit;

    localparam int ALUCTRL_W   = 5;
    localparam int IMMSRC_W    = 3;
    localparam int MUL_LATENCY = 2;
    localparam int DIV_LATENCY = 32;
    localparam int CNT_W       = 6;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_DIV   = 32'h0220C1B3;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_MRET  = 32'h30200073;
    localparam logic [31:0] I_CSRRW = 32'h300092F3;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          instr_d;
    logic                 valid_d;
    logic                 stall_e;
    logic                 flush_e;
    logic                 RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic [IMMSRC_W-1:0]  ImmSrcD;
    logic                 csr_we_e, mdu_start, mdu_busy, trap_req, mret_req;
    logic [3:0]           trap_cause;

    pipelined_ctrl_unit #(
        .ALUCTRL_W(ALUCTRL_W), .IMMSRC_W(IMMSRC_W), .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .ImmSrcD(ImmSrcD), .csr_we_e(csr_we_e),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy), .trap_req(trap_req),
        .trap_cause(trap_cause), .mret_req(mret_req)
    );

    always #5 clk = ~clk;

    // Expected meaning of one instruction, as listed in the ISA tables.
    typedef struct packed {
        logic       rw, mw, br, jp, as, csr;
        logic [1:0] res;
        logic [4:0] alu;
        logic       trap;
        logic [3:0] cause;
        logic       mret;
        logic [1:0] mdu;      // 0 none, 1 multiply, 2 divide/remainder
        logic       imm_chk;
        logic [2:0] imm;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t m_e;
    logic m_start;
    int   m_busy_left;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 5'b00001 : 5'b00000;
            3'b001:  return 5'b00100;
            3'b100:  return 5'b01001;
            3'b101:  return 5'b00101;
            3'b110:  return 5'b01000;
            default: return 5'b01010;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        e  = '0;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'b0000011: begin e.rw = 1; e.as = 1; e.res = 2'b01; e.imm_chk = 1; e.imm = 3'd0; end
            7'b0100011: begin e.mw = 1; e.as = 1; e.imm_chk = 1; e.imm = 3'd1; end
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
                    e.rw  = 1;
                    e.alu = (f3 == 3'd0) ? 5'b00010 : (f3 == 3'd4) ? 5'b00011 : 5'b00110;
                    e.mdu = (f3 == 3'd0) ? 2'd1 : 2'd2;
`else
                    e.trap = 1; e.cause = 4'd2;
`endif
                end else begin
                    e.rw = 1; e.alu = alu_of(f3, f7 == 7'b0100000);
                end
            end
            7'b0010011: begin e.rw = 1; e.as = 1; e.alu = alu_of(f3, 1'b0); e.imm_chk = 1; e.imm = 3'd0; end
            7'b1100011: begin e.br = 1; e.alu = 5'b00001; e.imm_chk = 1; e.imm = 3'd2; end
            7'b1101111: begin e.jp = 1; e.rw = 1; e.res = 2'b10; e.imm_chk = 1; e.imm = 3'd3; end
            7'b0110111: begin e.rw = 1; e.as = 1; e.alu = 5'b10000; e.imm_chk = 1; e.imm = 3'd4; end
            7'b1110011: begin
                if (i == I_ECALL) begin
                    e.trap = 1; e.cause = 4'd11;
                end else if (i == I_MRET) begin
                    e.mret = 1;
                end else if (f3 != 3'd0 && f3 != 3'd4) begin
                    e.rw = 1; e.csr = 1; e.res = 2'b11;
                end else begin
                    e.trap = 1; e.cause = 4'd2;
                end
            end
            default: begin e.trap = 1; e.cause = 4'd2; end
        endcase
        return e;
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b0110111, 7'b1110011};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  op;
        int          k;
        r  = $urandom;
        k  = $urandom_range(0, 11);
        f3 = 3'($urandom_range(0, 5));
        if (f3 == 3'd2) f3 = 3'd6;
        if (f3 == 3'd3) f3 = 3'd7;
        case (k)
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2: begin
                r[6:0] = 7'b0110011; r[14:12] = f3;
                r[31:25] = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            end
            3: begin
                r[6:0] = 7'b0110011; r[31:25] = 7'b0000001;
                k = $urandom_range(0, 2);
                r[14:12] = (k == 0) ? 3'd0 : (k == 1) ? 3'd4 : 3'd6;
            end
            4: begin r[6:0] = 7'b0010011; r[14:12] = f3; end
            5: r[6:0] = 7'b1100011;
            6: r[6:0] = 7'b1101111;
            7: r[6:0] = 7'b0110111;
            8: r = I_ECALL;
            9: r = I_MRET;
            10: begin
                r[6:0] = 7'b1110011;
                r[14:12] = 3'($urandom_range(1, 7));
                if (r[14:12] == 3'd4) r[14:12] = 3'd5;
            end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    r[6:0] = 7'b1110011;
                    r[14:12] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4;
                end else begin
                    op = 7'($urandom);
                    for (int t = 0; t < 20 && known_op(op); t++) op = 7'($urandom);
                    if (known_op(op)) op = 7'h7F;
                    r[6:0] = op;
                end
            end
        endcase
        return r;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl, input logic rs);
        exp_t d;
        instr_d = ins; valid_d = v; stall_e = st; flush_e = fl; rst = rs;
        d = ref_decode(ins);
        #1;
        if (d.imm_chk) check_eq("ImmSrcD", 32'(ImmSrcD), 32'(d.imm));
        @(posedge clk);
        m_start = 1'b0;
        if (!rs || fl) begin
            m_e = '0;
            m_busy_left = 0;
        end else if (st || m_busy_left > 0) begin
            m_e.trap = 1'b0; m_e.cause = 4'd0; m_e.mret = 1'b0;
            if (m_busy_left > 0) m_busy_left--;
        end else begin
            m_e = v ? d : '0;
            if (v && d.mdu != 2'd0) begin
                m_start = 1'b1;
                m_busy_left = ((d.mdu == 2'd1) ? MUL_LATENCY : DIV_LATENCY) - 1;
            end
        end
        @(negedge clk);
        check_eq("RegWriteE",   32'(RegWriteE),   32'(m_e.rw));
        check_eq("MemWriteE",   32'(MemWriteE),   32'(m_e.mw));
        check_eq("BranchE",     32'(BranchE),     32'(m_e.br));
        check_eq("JumpE",       32'(JumpE),       32'(m_e.jp));
        check_eq("ALUSrcE",     32'(ALUSrcE),     32'(m_e.as));
        check_eq("ResultSrcE",  32'(ResultSrcE),  32'(m_e.res));
        check_eq("ALUControlE", 32'(ALUControlE), 32'(m_e.alu));
        check_eq("csr_we_e",    32'(csr_we_e),    32'(m_e.csr));
        check_eq("trap_req",    32'(trap_req),    32'(m_e.trap));
        check_eq("mret_req",    32'(mret_req),    32'(m_e.mret));
        check_eq("mdu_start",   32'(mdu_start),   32'(m_start));
        check_eq("mdu_busy",    32'(mdu_busy),    32'(m_busy_left > 0));
        if (m_e.trap) check_eq("trap_cause", 32'(trap_cause), 32'(m_e.cause));
    endtask

    initial begin
        int busy_cycles;
        logic [31:0] ins;
        rst = 1'b0; instr_d = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        m_e = '0; m_start = 1'b0; m_busy_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("add_regwrite", 32'(RegWriteE), 32'd1);
        check_eq("add_alu", 32'(ALUControlE), 32'd0);
        check_eq("add_ressrc", 32'(ResultSrcE), 32'd0);
        check_eq("add_alusrc", 32'(ALUSrcE), 32'd0);

        step(I_ECALL, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("ecall_trap", 32'(trap_req), 32'd1);
        check_eq("ecall_cause", 32'(trap_cause), 32'd11);
        check_eq("ecall_regwrite", 32'(RegWriteE), 32'd0);
        step(I_MRET, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("ecall_pulse_end", 32'(trap_req), 32'd0);
        check_eq("mret_req", 32'(mret_req), 32'd1);
        step(I_CSRRW, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("csr_we", 32'(csr_we_e), 32'd1);
        check_eq("csr_ressrc", 32'(ResultSrcE), 32'd3);
        check_eq("csr_regwrite", 32'(RegWriteE), 32'd1);
        step(I_BAD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("bad_trap", 32'(trap_req), 32'd1);
        check_eq("bad_cause", 32'(trap_cause), 32'd2);
        step(I_BAD, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("flushstall_trap", 32'(trap_req), 32'd0);
        check_eq("flushstall_regwrite", 32'(RegWriteE), 32'd0);
        step(I_ADD, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("stall_hold_regwrite", 32'(RegWriteE), 32'd0);

`ifdef RV32M_EN
        step(I_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("div_start", 32'(mdu_start), 32'd1);
        check_eq("div_alu", 32'(ALUControlE), 32'd3);
        busy_cycles = 0;
        for (int c = 0; c < 100 && mdu_busy; c++) begin
            busy_cycles++;
            step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        check_eq("div_busy_cycles", 32'(busy_cycles), 32'(DIV_LATENCY - 1));
        step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("add_after_div_alu", 32'(ALUControlE), 32'd0);
        step(I_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid_div_busy", 32'(mdu_busy), 32'd0);
        check_eq("rst_mid_div_regwrite", 32'(RegWriteE), 32'd0);
        check_eq("rst_mid_div_trap", 32'(trap_req), 32'd0);
`else
        busy_cycles = 0;
        step(I_DIV, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("div_illegal_trap", 32'(trap_req), 32'd1);
        check_eq("div_illegal_cause", 32'(trap_cause), 32'd2);
        check_eq("div_no_busy", 32'(mdu_busy) + 32'(busy_cycles), 32'd0);
`endif

        for (int n = 0; n < 1500; n++) begin
            ins = gen_instr();
            step(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 6, !($urandom_range(0, 99) < 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_ctrl_unit.md
Name: pipelined_ctrl_unit

Overview:
- Parametrised successor to the single-cycle decode controller.
- Decodes the full 32-bit instruction in Decode (D), registers all control into the Execute-stage (E) pipeline register, and honours stall/flush from the hazard unit.
- Sequences multi-cycle MUL/DIV operations with an internal latency counter, and raises trap, CSR-access and MRET requests to the CSR file.
- Sits between the IF/ID register and the datapath E stage.

Parameters:
- ALUCTRL_W, 5, width of ALU control field.
- IMMSRC_W, 3, width of immediate-select field.
- MUL_LATENCY, 2, E-stage cycles for MUL (>=1).
- DIV_LATENCY, 32, E-stage cycles for DIV/REM (>=1).
- CNT_W, 6, latency counter width; must hold max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- instr_d  in  32  instruction in D.
- valid_d  in  1  instr_d is valid.
- stall_e  in  1  hazard unit holds the E register.
- flush_e  in  1  hazard unit bubbles the E register.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1 each  registered E-stage control.
- ResultSrcE  out  2  00=ALU, 01=mem, 10=PC+4, 11=CSR read data.
- ALUControlE  out  ALUCTRL_W  ALU operation.
- ImmSrcD  out  IMMSRC_W  combinational, D stage: 000 I, 001 S, 010 B, 011 J, 100 U.
- csr_we_e  out  1  CSR write in E.
- mdu_start  out  1  one-cycle pulse starting MUL/DIV.
- mdu_busy  out  1  high while an MDU op occupies E; the hazard unit stalls F/D/E.
- trap_req  out  1  one-cycle pulse on ECALL/illegal instruction.
- trap_cause  out  4  valid with trap_req: 2=illegal, 11=ECALL.
- mret_req  out  1  one-cycle pulse on MRET.

Behaviour:
- Reset (rst==0 at posedge): every registered output is 0, ALUControlE=0, ResultSrcE=00, state=RUN, counter=0. Reset mid-MDU aborts the op with no trap. ImmSrcD is combinational and not reset.
- Decode is combinational in D. On each clock the result enters E with priority: rst > flush_e (bubble: all E outputs 0) > stall_e or mdu_busy (hold) > load. When valid_d==0, a bubble is loaded.
- Opcodes decoded: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal, 0110111 lui, 1110011 system. Any other opcode is illegal.
- lui: RegWrite=1, ALUSrc=1, ALU op PASSB (10000).
- jal: RegWrite=1, ResultSrc=10. This fixes the legacy RegWrite=0 behaviour.
- ALU codes: ADD 00000, SUB 00001, MUL 00010, DIV 00011, SLL 00100, SRL 00101, REM 00110, OR 01000, XOR 01001, AND 01010, PASSB 10000.
  - R funct7 0100000 with funct3 000 is SUB.
  - Branches use SUB.
  - Load and store use ADD.
- System opcode:
  - 0x00000073: ECALL → trap.
  - 0x30200073: MRET → mret_req.
  - funct3 in {001, 010, 011, 101, 110, 111}: CSR op with RegWrite=1, ResultSrc=11, csr_we_e=1.
  - Anything else: illegal.
- Trap and MRET: trap_req or mret_req pulses in the cycle the instruction is loaded into E. The E entry is a bubble with all write enables 0. Not asserted on a flushed or stalled load.
- FSM:
  - RUN: loading a MUL or DIV/REM asserts mdu_start for 1 cycle, loads counter = latency-1, and moves to MDU_WAIT. If latency-1 == 0, the FSM stays in RUN.
  - MDU_WAIT: mdu_busy=1 and the counter decrements each cycle. When counter==0, go to RUN with mdu_busy=0 in that cycle.
  - flush_e in MDU_WAIT aborts: go to RUN, counter=0, E bubbled.
- flush_e and stall_e together: flush wins.

Optional Feature:
- Macro RV32M_EN.
- Defined: MUL/DIV/REM decode and the MDU FSM are compiled in.
- Undefined: R-type with funct7=0000001 is illegal (trap_req, cause 2). mdu_start and mdu_busy are tied 0, and the FSM and counter are absent.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3) with valid_d=1 → next cycle RegWriteE=1, ALUControlE=00000, ResultSrcE=00, ALUSrcE=0.
- RV32M_EN, DIV_LATENCY=32, div (0x0220C1B3) → mdu_start pulse, mdu_busy high exactly 31 cycles, E held, then a following add loads.
- 0x00000073 → trap_req=1 for one cycle with trap_cause=11, E write enables 0. 0x30200073 → mret_req pulse.
- csrrw x5,mstatus,x1 (0x300092F3) → csr_we_e=1, ResultSrcE=11, RegWriteE=1.
- Unknown opcode 0x0000007F → trap_req, cause 2. With stall_e=1 and flush_e=1 in the same cycle → E bubbled, no trap pulse.
- rst=0 during MDU_WAIT → all outputs 0 next edge, mdu_busy=0, state RUN.
